// File: rtl/mips_mc_ctrl_if.sv
// Control bus between the multi-cycle MIPS datapath and its controller.
// The master side is the datapath (supplies IR fields and the zero flag).
// The slave side is the controller (drives enables, selects and status).
interface mips_mc_ctrl_if #(
  parameter int unsigned ALU_OP_LENGTH = 3
);
  logic [5:0]               opcode;
  logic [5:0]               funct;
  logic                     zero;
  logic                     pc_wen;
  logic                     ir_wen;
  logic [1:0]               npc_sel;
  logic                     reg_write;
  logic                     mem_write;
  logic                     mem_read;
  logic                     alu_src;
  logic                     mem_to_reg;
  logic                     reg_dst;
  logic                     ext_op;
  logic [ALU_OP_LENGTH-1:0] alu_op;
  logic [2:0]               state;
  logic                     illegal;

  modport master (
    output opcode, funct, zero,
    input  pc_wen, ir_wen, npc_sel, reg_write, mem_write, mem_read,
           alu_src, mem_to_reg, reg_dst, ext_op, alu_op, state, illegal
  );

  modport slave (
    input  opcode, funct, zero,
    output pc_wen, ir_wen, npc_sel, reg_write, mem_write, mem_read,
           alu_src, mem_to_reg, reg_dst, ext_op, alu_op, state, illegal
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS controller: IF -> ID -> EX -> MEM -> WB FSM for
// addu/subu/ori/lui/lw/sw/beq/j, with a sticky illegal-instruction flag.
module mips_mc_ctrl #(
  parameter int unsigned ALU_OP_LENGTH = 3
) (
  input logic           clk,
  input logic           rst,
  mips_mc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StEx  = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4
  } state_e;

  localparam logic [ALU_OP_LENGTH-1:0] AluAdd = ALU_OP_LENGTH'(0);
  localparam logic [ALU_OP_LENGTH-1:0] AluSub = ALU_OP_LENGTH'(1);
  localparam logic [ALU_OP_LENGTH-1:0] AluOr  = ALU_OP_LENGTH'(2);
  localparam logic [ALU_OP_LENGTH-1:0] AluLui = ALU_OP_LENGTH'(3);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  // Instruction decode from the IR fields
  logic is_addu, is_subu, is_rtype, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_legal;

  assign is_addu  = (bus.opcode == 6'b000000) && (bus.funct == 6'b100001);
  assign is_subu  = (bus.opcode == 6'b000000) && (bus.funct == 6'b100011);
  assign is_rtype = is_addu | is_subu;
  assign is_ori   = (bus.opcode == 6'b001101);
  assign is_lui   = (bus.opcode == 6'b001111);
  assign is_lw    = (bus.opcode == 6'b100011);
  assign is_sw    = (bus.opcode == 6'b101011);
  assign is_beq   = (bus.opcode == 6'b000100);
  assign is_j     = (bus.opcode == 6'b000010);
  assign is_legal = is_rtype | is_ori | is_lui | is_lw | is_sw | is_beq | is_j;

  logic                     pc_wen, ir_wen, reg_write, mem_write, mem_read;
  logic [1:0]               npc_sel;
  logic                     sel_en;
  logic                     alu_src, mem_to_reg, reg_dst, ext_op;
  logic [ALU_OP_LENGTH-1:0] alu_op;

  // State and sticky illegal flag; reset wins asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIf;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state, write enables and mux selects
  always_comb begin
    state_d    = StIf;
    illegal_d  = illegal_q;
    pc_wen     = 1'b0;
    ir_wen     = 1'b0;
    npc_sel    = 2'b00;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    sel_en     = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    ext_op     = 1'b0;
    alu_op     = AluAdd;

    unique case (state_q)
      StIf: begin
        ir_wen  = 1'b1;
        pc_wen  = 1'b1;
        state_d = StId;
      end
      StId: begin
        sel_en = 1'b1;
        if (is_j) begin
          pc_wen  = 1'b1;
          npc_sel = 2'b10;
          state_d = StIf;
        end else if (!is_legal) begin
          illegal_d = 1'b1;
          state_d   = StIf;
        end else begin
          state_d = StEx;
        end
      end
      StEx: begin
        sel_en = 1'b1;
        if (is_beq) begin
          pc_wen  = bus.zero;
          npc_sel = 2'b01;
          state_d = StIf;
        end else if (is_lw || is_sw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        sel_en = 1'b1;
        if (is_lw) begin
          mem_read = 1'b1;
          state_d  = StWb;
        end else begin
          mem_write = is_sw;
          state_d   = StIf;
        end
      end
      StWb: begin
        sel_en    = 1'b1;
        reg_write = 1'b1;
        state_d   = StIf;
      end
      // Unused encodings recover to IF with everything quiet
      default: state_d = StIf;
    endcase

    if (sel_en) begin
      reg_dst    = is_rtype;
      alu_src    = is_ori | is_lui | is_lw | is_sw;
      mem_to_reg = is_lw;
      ext_op     = is_lw | is_sw | is_beq;
      if (is_subu || is_beq) begin
        alu_op = AluSub;
      end else if (is_ori) begin
        alu_op = AluOr;
      end else if (is_lui) begin
        alu_op = AluLui;
      end else begin
        alu_op = AluAdd;
      end
    end

    // Reset must silence every enable immediately, not at the next edge
    if (rst) begin
      pc_wen     = 1'b0;
      ir_wen     = 1'b0;
      npc_sel    = 2'b00;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      ext_op     = 1'b0;
      alu_op     = AluAdd;
    end
  end

  assign bus.pc_wen     = pc_wen;
  assign bus.ir_wen     = ir_wen;
  assign bus.npc_sel    = npc_sel;
  assign bus.reg_write  = reg_write;
  assign bus.mem_write  = mem_write;
  assign bus.mem_read   = mem_read;
  assign bus.alu_src    = alu_src;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_dst    = reg_dst;
  assign bus.ext_op     = ext_op;
  assign bus.alu_op     = alu_op;
  assign bus.state      = state_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 SHALL have parameter ALU_OP_LENGTH, default 3, giving the alu_op width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port opcode, input, 6, the IR bits [31:26].
REQ-005 SHALL have port funct, input, 6, the IR bits [5:0].
REQ-006 SHALL have port zero, input, 1, the ALU equality flag, used by beq.
REQ-007 SHALL have outputs pc_wen and ir_wen, each 1 bit, the PC and IR load enables.
REQ-008 SHALL have output npc_sel, 2 bits: 00 = pc+4, 01 = branch target, 10 = jump target.
REQ-009 SHALL have outputs reg_write, mem_write and mem_read, each 1 bit.
REQ-010 SHALL have outputs alu_src, mem_to_reg, reg_dst and ext_op, each 1 bit: ext_op 1 = sign-extend, 0 = zero-extend.
REQ-011 SHALL have output alu_op, ALU_OP_LENGTH bits: ADD = 0, SUB = 1, OR = 2, LUI = 3 (imm << 16).
REQ-012 SHALL have outputs state (3 bits, current-state encoding) and illegal (1 bit, sticky).

Function
REQ-013 SHALL implement a multi-cycle FSM with states IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4; codes 5-7 SHALL go to IF on the next edge.
REQ-014 SHALL decode: R-type (000000) addu (funct 100001) and subu (funct 100011); ori 001101; lui 001111; lw 100011; sw 101011; beq 000100; j 000010. Anything else SHALL be illegal, including R-type with any other funct.
REQ-015 In IF, SHALL assert ir_wen = 1, pc_wen = 1 and npc_sel = 00, then go to ID.
REQ-016 In ID:
- j: SHALL assert pc_wen = 1 with npc_sel = 10, then go to IF.
- illegal: SHALL set illegal, perform no writes, then go to IF.
- all other decoded instructions: SHALL go to EX.
REQ-017 In EX:
- beq: SHALL assert pc_wen = zero with npc_sel = 01, then go to IF.
- lw/sw: SHALL go to MEM.
- R-type/ori/lui: SHALL go to WB.
REQ-018 In MEM:
- lw: SHALL assert mem_read = 1, then go to WB.
- sw: SHALL assert mem_write = 1, then go to IF.
REQ-019 In WB, SHALL assert reg_write = 1, then go to IF.
REQ-020 Instruction latencies, IF through last state, SHALL be: j 2, beq 3, R-type/ori/lui/sw 4, lw 5.
REQ-021 Mux selects and alu_op SHALL be decoded from opcode/funct and held constant in ID, EX, MEM and WB:
- reg_dst = 1 for R-type only.
- alu_src = 1 for ori/lui/lw/sw.
- mem_to_reg = 1 for lw only.
- ext_op = 1 for lw/sw/beq.
- alu_op: SUB for subu/beq, OR for ori, LUI for lui, ADD otherwise.
REQ-022 In IF, all selects SHALL be 0 and alu_op SHALL be ADD.
REQ-023 Write enables (pc_wen, ir_wen, reg_write, mem_write) SHALL be asserted for exactly one cycle per state visit, and never outside the states named above.
REQ-024 mem_read and mem_write SHALL never be asserted in the same cycle.
REQ-025 illegal SHALL remain 1 until reset, and SHALL NOT stall the FSM.
REQ-026 opcode/funct SHALL be sampled only in ID, EX, MEM and WB. Values in IF (IR is loading) SHALL NOT affect outputs.

Reset
REQ-027 While rst = 1, the block SHALL hold state = IF, illegal = 0, and all other outputs 0 (including pc_wen and ir_wen), with alu_op = ADD.
REQ-028 Assertion of rst in any state, including mid-lw in MEM, SHALL take effect immediately: no write enable may remain high after rst rises.
REQ-029 The first rising edge after rst falls SHALL complete the IF cycle.

Verification
REQ-030 addu (000000/100001) after reset:
- IF: ir_wen = 1, pc_wen = 1.
- ID: no enables.
- EX: alu_op = 0, reg_dst = 1.
- WB: reg_write = 1.
- Back in IF on cycle 5.
REQ-031 lw: MEM asserts mem_read = 1 and ext_op = 1; WB asserts reg_write = 1 with mem_to_reg = 1. Total 5 cycles.
REQ-032 beq with zero = 1: EX asserts pc_wen = 1 and npc_sel = 01. With zero = 0: pc_wen = 0. Both cases return to IF after 3 cycles.
REQ-033 j: ID asserts pc_wen = 1 and npc_sel = 10, then IF. Total 2 cycles.
REQ-034 opcode 111111 in ID: illegal rises to 1 and stays 1; no enables are asserted; the next instruction executes normally.
REQ-035 rst pulsed high mid-cycle while in MEM for sw: mem_write drops to 0 asynchronously, state reads 0, and IF resumes after release.
